pipe_top: RTL and testbench



---
 rtl/pipe_pkg.sv | 71 +++++++
 rtl/pipe_imem.sv | 16 +
 rtl/pipe_top.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_top.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings, ALU op set and stage-register layouts for the pipe_top RV32I core.
// Pure declarations: no latency, no flow control.
package pipe_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifex_t;

    typedef struct packed {
        logic        vld;
        logic        we;
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] result;
    } exwb_t;

    // alt selects SUB/SRA; callers only raise it where the encoding allows it
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipe_imem.sv
// Instruction ROM, contents preloaded from outside; combinational word read.
// Zero latency, never stalls; address wraps modulo depth.
module pipe_imem
    import pipe_pkg::*;
#(
    parameter int IMEM_WORDS = 1024
) (
    input  logic [$clog2(IMEM_WORDS)-1:0] i_word_addr,
    output logic [31:0]                   o_rdata
);

    logic [31:0] mem [0:IMEM_WORDS-1];

    assign o_rdata = mem[i_word_addr];

endmodule

// File: rtl/pipe_top.sv
// 3-stage (IF/EX/WB) RV32I-subset core with private imem, dmem and register file; 1 instr/cycle.
// Taken branch/jump costs 1 bubble; RAW on the WB result stalls 1 cycle unless PIPE_TOP_FORWARD_EN.
module pipe_top
    import pipe_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    // rst_n is active-high despite its name
    logic w_rst;
    assign w_rst = rst_n;

    logic [31:0] r_pc;
    ifex_t       r_ifex;
    exwb_t       r_exwb;
    logic [31:0] r_load_dat;
    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    logic [31:0] w_fetch;

    pipe_imem #(.IMEM_WORDS(IMEM_WORDS)) INST1 (
        .i_word_addr (r_pc[IAW+1:2]),
        .o_rdata     (w_fetch)
    );

    logic [31:0] w_instr;
    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_instr  = r_ifex.instr;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_f3     = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_f7     = w_instr[31:25];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {w_instr[31:12], 12'h000};
    assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    logic        w_legal, w_use_rs1, w_use_rs2, w_we, w_is_load, w_is_store;
    logic        w_is_branch, w_is_jal, w_is_jalr, w_a_pc, w_b_imm;
    logic [31:0] w_imm;
    alu_op_e     w_alu_op;

    always_comb begin
        w_legal     = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_we        = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_a_pc      = 1'b0;
        w_b_imm     = 1'b1;
        w_imm       = w_imm_i;
        w_alu_op    = ALU_ADD;
        case (w_opcode)
            OP_LUI:    begin w_legal = 1'b1; w_we = 1'b1; w_imm = w_imm_u; w_alu_op = ALU_PASSB; end
            OP_AUIPC:  begin w_legal = 1'b1; w_we = 1'b1; w_imm = w_imm_u; w_a_pc = 1'b1; end
            OP_JAL:    begin w_legal = 1'b1; w_we = 1'b1; w_is_jal = 1'b1; end
            OP_JALR:   begin w_legal = (w_f3 == 3'b000); w_use_rs1 = 1'b1; w_we = 1'b1; w_is_jalr = 1'b1; end
            OP_BRANCH: begin
                w_legal     = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_is_branch = 1'b1;
            end
            OP_LOAD:   begin w_legal = (w_f3 == F3_W); w_use_rs1 = 1'b1; w_we = 1'b1; w_is_load = 1'b1; end
            OP_STORE:  begin
                w_legal    = (w_f3 == F3_W);
                w_use_rs1  = 1'b1;
                w_use_rs2  = 1'b1;
                w_is_store = 1'b1;
                w_imm      = w_imm_s;
            end
            OP_IMM:    begin
                w_use_rs1 = 1'b1;
                w_we      = 1'b1;
                w_alu_op  = f3_to_alu(w_f3, (w_f3 == F3_SR) && (w_f7 == F7_ALT));
                if (w_f3 == F3_SLL)     w_legal = (w_f7 == F7_BASE);
                else if (w_f3 == F3_SR) w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                else                    w_legal = 1'b1;
            end
            OP_REG:    begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_we      = 1'b1;
                w_b_imm   = 1'b0;
                w_alu_op  = f3_to_alu(w_f3, w_f7 == F7_ALT);
                w_legal   = (w_f7 == F7_BASE) ||
                            ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
            end
            default: ;
        endcase
    end

    logic [31:0] w_wb_dat, w_rs1_val, w_rs2_val;
    logic        w_hit_rs1, w_hit_rs2, w_stall;

    assign w_wb_dat  = r_exwb.is_load ? r_load_dat : r_exwb.result;
    assign w_hit_rs1 = w_use_rs1 && r_exwb.vld && r_exwb.we && (r_exwb.rd != 5'd0) && (r_exwb.rd == w_rs1);
    assign w_hit_rs2 = w_use_rs2 && r_exwb.vld && r_exwb.we && (r_exwb.rd != 5'd0) && (r_exwb.rd == w_rs2);

`ifdef PIPE_TOP_FORWARD_EN
    assign w_rs1_val = w_hit_rs1 ? w_wb_dat : regs[w_rs1];
    assign w_rs2_val = w_hit_rs2 ? w_wb_dat : regs[w_rs2];
    assign w_stall   = 1'b0;
`else
    // the register file is written at the end of WB, so EX must wait one cycle
    assign w_rs1_val = regs[w_rs1];
    assign w_rs2_val = regs[w_rs2];
    assign w_stall   = r_ifex.vld && w_legal && (w_hit_rs1 || w_hit_rs2);
`endif

    logic [31:0] w_alu_a, w_alu_b, w_alu_res;

    assign w_alu_a = w_a_pc ? r_ifex.pc : w_rs1_val;
    assign w_alu_b = w_b_imm ? w_imm : w_rs2_val;

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD:   w_alu_res = w_alu_a + w_alu_b;
            ALU_SUB:   w_alu_res = w_alu_a - w_alu_b;
            ALU_SLL:   w_alu_res = w_alu_a << w_alu_b[4:0];
            ALU_SLT:   w_alu_res = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            ALU_SLTU:  w_alu_res = {31'd0, w_alu_a < w_alu_b};
            ALU_XOR:   w_alu_res = w_alu_a ^ w_alu_b;
            ALU_SRL:   w_alu_res = w_alu_a >> w_alu_b[4:0];
            ALU_SRA:   w_alu_res = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
            ALU_OR:    w_alu_res = w_alu_a | w_alu_b;
            ALU_AND:   w_alu_res = w_alu_a & w_alu_b;
            ALU_PASSB: w_alu_res = w_alu_b;
            default:   w_alu_res = '0;
        endcase
    end

    logic        w_br_cond, w_exec, w_redirect;
    logic [31:0] w_target, w_link;

    always_comb begin
        w_br_cond = 1'b0;
        case (w_f3)
            F3_BEQ:  w_br_cond = (w_rs1_val == w_rs2_val);
            F3_BNE:  w_br_cond = (w_rs1_val != w_rs2_val);
            F3_BLT:  w_br_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            F3_BGE:  w_br_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            F3_BLTU: w_br_cond = (w_rs1_val <  w_rs2_val);
            F3_BGEU: w_br_cond = (w_rs1_val >= w_rs2_val);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_exec     = r_ifex.vld && w_legal && !w_stall;
    assign w_redirect = w_exec && (w_is_jal || w_is_jalr || (w_is_branch && w_br_cond));
    assign w_link     = r_ifex.pc + 32'd4;
    assign w_target   = w_is_jalr ? {w_alu_res[31:1], 1'b0} :
                        w_is_jal  ? (r_ifex.pc + w_imm_j) : (r_ifex.pc + w_imm_b);

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_pc   <= RESET_PC;
            r_ifex <= '{vld: 1'b0, pc: RESET_PC, instr: NOP_INSTR};
            r_exwb <= '0;
        end else begin
            if (w_redirect) begin
                r_pc       <= w_target;
                r_ifex.vld <= 1'b0;
            end else if (!w_stall) begin
                r_pc   <= r_pc + 32'd4;
                r_ifex <= '{vld: 1'b1, pc: r_pc, instr: w_fetch};
            end
            r_exwb <= '{vld: w_exec, we: w_exec && w_we, is_load: w_is_load, rd: w_rd,
                        result: (w_is_jal || w_is_jalr) ? w_link : w_alu_res};
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (r_exwb.vld && r_exwb.we && (r_exwb.rd != 5'd0)) begin
            regs[r_exwb.rd] <= w_wb_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_rst && w_exec && w_is_store) dmem[w_alu_res[DAW+1:2]] <= w_rs2_val;
        if (w_exec && w_is_load) r_load_dat <= dmem[w_alu_res[DAW+1:2]];
    end

endmodule

// File: tb/tb_pipe_top.sv
// Directed program-level bench for pipe_top: loads small programs into INST1.mem and
// checks register file, data memory and pipeline state hierarchically.
module tb_pipe_top;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pipe_top dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v, s, d;
        v = imm; s = rs1; d = rd;
        return {v[11:0], s[4:0], f3, d[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [31:0] t, s, d;
        t = rs2; s = rs1; d = rd;
        return {f7, t[4:0], s[4:0], f3, d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v, t, s;
        v = imm; t = rs2; s = rs1;
        return {v[11:5], t[4:0], s[4:0], 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] v, t, s;
        v = imm; t = rs2; s = rs1;
        return {v[12], v[10:5], t[4:0], s[4:0], f3, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction

    task automatic put(input int byte_addr, input logic [31:0] word);
        dut.INST1.mem[byte_addr >> 2] = word;
    endtask

    task automatic begin_prog();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) dut.INST1.mem[i] = 32'h0000_0013;
    endtask

    task automatic run_prog(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic count_nonzero(output int n);
        n = 0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] != 32'd0) n++;
    endtask

    int          nz;
    int          cyc;
    logic [31:0] saved;

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) dut.INST1.mem[i] = 32'h0000_0013;

        // power-on reset
        repeat (2) @(negedge clk);
        chk("rst_pc", dut.r_pc, 32'h0);
        chk("rst_ifex_vld", {31'd0, dut.r_ifex.vld}, 32'd0);
        chk("rst_exwb_vld", {31'd0, dut.r_exwb.vld}, 32'd0);
        count_nonzero(nz);
        chk("rst_regs_zero", nz, 32'd0);

        // BLT taken over a signed negative operand
        begin_prog();
        put(0,  addi(1, 0, 5));
        put(4,  addi(2, 0, -3));
        put(8,  enc_b(8, 1, 2, 3'd4));
        put(12, addi(3, 0, 1));
        put(16, addi(4, 0, 7));
        run_prog(20);
        chk("blt_x1", dut.regs[1], 32'd5);
        chk("blt_x2", dut.regs[2], 32'hFFFF_FFFD);
        chk("blt_x3_skipped", dut.regs[3], 32'd0);
        chk("blt_x4", dut.regs[4], 32'd7);

        // signed vs unsigned compare on 0xFFFFFFFF vs 1
        begin_prog();
        put(0,  addi(1, 0, -1));
        put(4,  addi(2, 0, 1));
        put(8,  enc_b(8, 1, 2, 3'd4));
        put(12, addi(5, 0, 1));
        put(16, enc_b(8, 1, 2, 3'd6));
        put(20, addi(6, 0, 1));
        run_prog(20);
        chk("blt_not_taken_x5", dut.regs[5], 32'd1);
        chk("bltu_taken_x6", dut.regs[6], 32'd0);

        // dependency chain and its cycle count from reset release
        begin_prog();
        put(0, addi(1, 0, 1));
        put(4, enc_r(7'h00, 1, 1, 3'd0, 2));
        put(8, enc_r(7'h00, 2, 2, 3'd0, 3));
        @(negedge clk);
        rst_n = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cyc == 0 && dut.regs[3] == 32'd4) cyc = c;
        end
        chk("chain_x2", dut.regs[2], 32'd2);
        chk("chain_x3", dut.regs[3], 32'd4);
`ifdef PIPE_TOP_FORWARD_EN
        chk("chain_cycles", cyc, 32'd5);
`else
        chk("chain_cycles", cyc, 32'd7);
`endif

        // store, load and load-use
        begin_prog();
        put(0,  addi(1, 0, 32'h55));
        put(4,  enc_s(8, 1, 0));
        put(8,  enc_i(8, 0, 3'b010, 6, 7'h03));
        put(12, enc_r(7'h00, 6, 6, 3'd0, 7));
        run_prog(20);
        chk("mem_dmem2", dut.dmem[2], 32'h55);
        chk("mem_x6", dut.regs[6], 32'h55);
        chk("mem_x7", dut.regs[7], 32'hAA);

        // x0 discard, unsupported encoding, JAL and JALR with odd target
        begin_prog();
        put(0,  addi(0, 0, 9));
        put(4,  addi(8, 0, 2));
        put(12, enc_r(7'h01, 8, 8, 3'd0, 13));
        put(16, enc_j(8, 1));
        put(20, addi(2, 0, 1));
        put(24, addi(3, 0, 3));
        put(28, enc_i(41, 0, 3'b000, 9, 7'h67));
        put(32, addi(10, 0, 1));
        put(36, addi(10, 0, 2));
        put(40, addi(11, 0, 4));
        run_prog(25);
        chk("x0_reads_zero", dut.regs[0], 32'd0);
        chk("x0_not_forwarded_x8", dut.regs[8], 32'd2);
        chk("illegal_no_write_x13", dut.regs[13], 32'd0);
        chk("jal_link_x1", dut.regs[1], 32'h14);
        chk("jal_skipped_x2", dut.regs[2], 32'd0);
        chk("jal_target_x3", dut.regs[3], 32'd3);
        chk("jalr_link_x9", dut.regs[9], 32'h20);
        chk("jalr_skipped_x10", dut.regs[10], 32'd0);
        chk("jalr_target_x11", dut.regs[11], 32'd4);

        // reset in the middle of a store loop
        begin_prog();
        put(0, addi(1, 1, 1));
        put(4, enc_s(64, 1, 0));
        put(8, enc_j(-8, 0));
        run_prog(30);
        saved = dut.dmem[16];
        chk("loop_stored", {31'd0, saved != 32'd0}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_store", dut.dmem[16], saved);
        chk("midrst_pc", dut.r_pc, 32'h0);
        count_nonzero(nz);
        chk("midrst_regs_zero", nz, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("restart_pc", dut.r_pc, 32'h4);
        chk("restart_ifex_pc", dut.r_ifex.pc, 32'h0);
        repeat (2) @(negedge clk);
        chk("restart_x1", dut.regs[1], 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
